// File: rtl/sliding_window_gen_if.sv
// Pixel-stream and window-output signal bundle for sliding_window_gen.
// master drives the pixel stream; slave is the window generator.
interface sliding_window_gen_if #(
  parameter int DW    = 8,
  parameter int WIN   = 11,
  parameter int CNT_W = 21
) ();

  logic                    din_valid;
  logic [DW-1:0]           din;
  logic                    sof;
  logic [WIN*WIN*DW-1:0]   dout;
  logic                    dout_valid;
  logic [15:0]             cen_row;
  logic [15:0]             cen_col;
  logic                    start_flag;
  logic [CNT_W-1:0]        cnt;
  logic                    complete;

  modport master (
    output din_valid, din, sof,
    input  dout, dout_valid, cen_row, cen_col, start_flag, cnt, complete
  );

  modport slave (
    input  din_valid, din, sof,
    output dout, dout_valid, cen_row, cen_col, start_flag, cnt, complete
  );

endinterface

// File: rtl/sliding_window_gen.sv
// Streaming WINxWIN window generator: WIN-1 cascaded line buffers feed a
// WINxWIN shift array; one window per accepted pixel once fully in-image.
module sliding_window_gen #(
  parameter int DW    = 8,
  parameter int WIN   = 11,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CNT_W = 21
) (
  input  logic                clk,
  input  logic                rst,
  sliding_window_gen_if.slave bus
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int HALF  = (WIN - 1) / 2;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_EDGE = COL_W'(WIN - 1);
  localparam logic [ROW_W-1:0] ROW_EDGE = ROW_W'(WIN - 1);

  logic                accept;
  logic [COL_W-1:0]    col_q;
  logic [COL_W-1:0]    col_eff;
  logic [ROW_W-1:0]    row_q;
  logic [ROW_W-1:0]    row_eff;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_eff;
  logic                last_pix;
  logic                win_ok;
  logic                first_win;

  logic [DW-1:0]       lb_mem [WIN-1][IMG_W];
  logic [DW-1:0]       lb_rd  [WIN-1];
  logic [DW-1:0]       col_new [WIN];
  logic [DW-1:0]       win_q  [WIN][WIN];
  logic [WIN*WIN*DW-1:0] dout_flat;

  logic                dout_valid_q;
  logic                start_q;
  logic                complete_q;
  logic [15:0]         cen_row_q;
  logic [15:0]         cen_col_q;

  assign accept = bus.din_valid;

  // A qualified sof makes the current pixel (0,0) regardless of the counters.
  assign col_eff = bus.sof ? '0 : col_q;
  assign row_eff = bus.sof ? '0 : row_q;
  assign cnt_eff = bus.sof ? '0 : cnt_q;

  assign last_pix  = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
  assign win_ok    = (row_eff >= ROW_EDGE) && (col_eff >= COL_EDGE);
  assign first_win = (row_eff == ROW_EDGE) && (col_eff == COL_EDGE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      if (last_pix) begin
        col_q <= '0;
        row_q <= '0;
        cnt_q <= '0;
      end else if (col_eff == COL_LAST) begin
        col_q <= '0;
        row_q <= row_eff + 1'b1;
        cnt_q <= cnt_eff + 1'b1;
      end else begin
        col_q <= col_eff + 1'b1;
        row_q <= row_eff;
        cnt_q <= cnt_eff + 1'b1;
      end
    end
  end

  // Read-before-write: each buffer hands its old entry down the cascade.
  always_comb begin
    for (int k = 0; k < WIN - 1; k++) begin
      lb_rd[k] = lb_mem[k][col_eff];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_mem[0][col_eff] <= bus.din;
      for (int k = 1; k < WIN - 1; k++) begin
        lb_mem[k][col_eff] <= lb_rd[k-1];
      end
    end
  end

  // Newest column: row WIN-1 is the incoming pixel, row 0 the oldest line.
  always_comb begin
    col_new[WIN-1] = bus.din;
    for (int r = 0; r < WIN - 1; r++) begin
      col_new[r] = lb_rd[WIN-2-r];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN; c++) begin
          win_q[r][c] <= '0;
        end
      end
      dout_valid_q <= 1'b0;
      start_q      <= 1'b0;
      complete_q   <= 1'b0;
      cen_row_q    <= '0;
      cen_col_q    <= '0;
    end else begin
      dout_valid_q <= accept && win_ok;
      start_q      <= accept && first_win;
      complete_q   <= accept && last_pix;
      if (accept) begin
        for (int r = 0; r < WIN; r++) begin
          for (int c = 0; c < WIN - 1; c++) begin
            win_q[r][c] <= win_q[r][c+1];
          end
          win_q[r][WIN-1] <= col_new[r];
        end
        if (win_ok) begin
          cen_row_q <= 16'(row_eff) - 16'(HALF);
          cen_col_q <= 16'(col_eff) - 16'(HALF);
        end
      end
    end
  end

  always_comb begin
    dout_flat = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        dout_flat[((r*WIN+c)*DW) +: DW] = win_q[r][c];
      end
    end
  end

  assign bus.dout       = dout_flat;
  assign bus.dout_valid = dout_valid_q;
  assign bus.cen_row    = cen_row_q;
  assign bus.cen_col    = cen_col_q;
  assign bus.start_flag = start_q;
  assign bus.cnt        = cnt_q;
  assign bus.complete   = complete_q;

endmodule

// File: tb/tb_sliding_window_gen.sv
// Bench for sliding_window_gen: 3x3 windows over a 16x12 image, checked
// against an image-array reference model every cycle.
module tb_sliding_window_gen;

  localparam int DW    = 8;
  localparam int WIN   = 3;
  localparam int IMG_W = 16;
  localparam int IMG_H = 12;
  localparam int CNT_W = 8;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int FW    = WIN * WIN * DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sliding_window_gen_if #(.DW(DW), .WIN(WIN), .CNT_W(CNT_W)) bus ();

  sliding_window_gen #(
    .DW(DW), .WIN(WIN), .IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // reference model: linear position of next pixel plus the frame image
  int          m_idx;
  int          img [IMG_H][IMG_W];
  logic        e_valid, e_start, e_complete, e_known;
  logic [FW-1:0] e_dout;
  int          e_cnt, e_crow, e_ccol;

  int win_cnt, compl_cnt, start_cnt, total_acc, start_at;

  typedef struct {
    int stall_mode;   // 0 none, 3 every third cycle, 99 random
    int pat;          // 0 raster value, 1 random value
    bit use_sof;
    int exp_win;
    int exp_compl;
    int exp_first;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0;
    e_valid = 1'b0; e_start = 1'b0; e_complete = 1'b0;
    e_dout = '0; e_known = 1'b1;
    e_cnt = 0; e_crow = 0; e_ccol = 0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic [DW-1:0] d);
    int r, c;
    e_valid = 1'b0; e_start = 1'b0; e_complete = 1'b0;
    if (v) begin
      if (s) m_idx = 0;
      r = m_idx / IMG_W;
      c = m_idx % IMG_W;
      img[r][c] = int'(d);
      e_valid    = (r >= WIN-1) && (c >= WIN-1);
      e_start    = (r == WIN-1) && (c == WIN-1);
      e_complete = (m_idx == NPIX-1);
      if (e_valid) begin
        for (int wr = 0; wr < WIN; wr++)
          for (int wc = 0; wc < WIN; wc++)
            e_dout[((wr*WIN+wc)*DW) +: DW] = DW'(img[r-(WIN-1)+wr][c-(WIN-1)+wc]);
        e_crow = r - (WIN-1)/2;
        e_ccol = c - (WIN-1)/2;
        e_known = 1'b1;
      end else begin
        e_known = 1'b0;
      end
      m_idx = (m_idx + 1) % NPIX;
      e_cnt = m_idx;
    end
  endtask

  task automatic check_outputs();
    chk("dout_valid", FW'(bus.dout_valid), FW'(e_valid));
    chk("start_flag", FW'(bus.start_flag), FW'(e_start));
    chk("complete",   FW'(bus.complete),   FW'(e_complete));
    chk("cnt",        FW'(bus.cnt),        FW'(e_cnt));
    if (e_valid) begin
      chk("window",  bus.dout,          e_dout);
      chk("cen_row", FW'(bus.cen_row),  FW'(e_crow));
      chk("cen_col", FW'(bus.cen_col),  FW'(e_ccol));
    end else if (e_known) begin
      chk("dout_hold", bus.dout, e_dout);
    end
    if (bus.dout_valid) win_cnt++;
    if (bus.complete)   compl_cnt++;
    if (bus.start_flag) begin
      start_cnt++;
      start_at = total_acc;
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
    bus.din_valid = v;
    bus.sof       = s;
    bus.din       = d;
    @(posedge clk);
    if (v) total_acc++;
    model_step(v, s, d);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_dout",       bus.dout,             '0);
    chk("rst_dout_valid", FW'(bus.dout_valid),  '0);
    chk("rst_start",      FW'(bus.start_flag),  '0);
    chk("rst_complete",   FW'(bus.complete),    '0);
    chk("rst_cnt",        FW'(bus.cnt),         '0);
    chk("rst_cen_row",    FW'(bus.cen_row),     '0);
    chk("rst_cen_col",    FW'(bus.cen_col),     '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_frame(input vec_t v, output int first);
    int acc, cyc, r, c;
    logic stall;
    logic [DW-1:0] d;
    acc = 0; cyc = 0; first = -1;
    win_cnt = 0; compl_cnt = 0;
    while (acc < NPIX && cyc < 4*NPIX) begin
      if (v.stall_mode == 3)       stall = (cyc % 3 == 2);
      else if (v.stall_mode == 99) stall = ($urandom_range(0, 3) == 0);
      else                         stall = 1'b0;
      if (stall) begin
        step(1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
      end else begin
        r = acc / IMG_W;
        c = acc % IMG_W;
        d = (v.pat != 0) ? DW'($urandom) : DW'((r*16 + c) % 256);
        step(1'b1, v.use_sof && (acc == 0), d);
        acc++;
        if (first < 0 && bus.dout_valid) first = acc;
      end
      cyc++;
    end
    if (acc < NPIX) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: accepted %0d of %0d", acc, NPIX);
    end
  endtask

  initial begin
    int first;
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.din       = '0;
    total_acc = 0; start_cnt = 0; start_at = 0; win_cnt = 0; compl_cnt = 0;

    vecs[0] = '{stall_mode: 0,  pat: 0, use_sof: 1'b0, exp_win: 140, exp_compl: 1, exp_first: 35};
    vecs[1] = '{stall_mode: 3,  pat: 0, use_sof: 1'b1, exp_win: 140, exp_compl: 1, exp_first: 35};
    vecs[2] = '{stall_mode: 0,  pat: 1, use_sof: 1'b0, exp_win: 140, exp_compl: 1, exp_first: 35};
    vecs[3] = '{stall_mode: 99, pat: 1, use_sof: 1'b1, exp_win: 140, exp_compl: 1, exp_first: 35};

    do_reset();

    // first window of a frame, then a reset in the middle of the frame
    first = -1;
    for (int i = 0; i < 35; i++) begin
      step(1'b1, 1'b0, DW'(i));
      if (first < 0 && bus.dout_valid) first = i + 1;
    end
    chk("first_valid_accepts", FW'(first), FW'(35));
    chk("first_start", FW'(bus.start_flag), FW'(1));
    begin
      logic [FW-1:0] w;
      w = bus.dout;
      chk("first_el00", FW'(w[7:0]),   FW'(0));
      chk("first_el11", FW'(w[39:32]), FW'(17));
      chk("first_el22", FW'(w[71:64]), FW'(34));
    end
    chk("first_cen_row", FW'(bus.cen_row), FW'(1));
    chk("first_cen_col", FW'(bus.cen_col), FW'(1));
    for (int i = 35; i < 80; i++) step(1'b1, 1'b0, DW'(i));
    do_reset();

    // table of full frames, run back to back
    for (int k = 0; k < 4; k++) begin
      run_frame(vecs[k], first);
      chk($sformatf("vec%0d_windows", k),   FW'(win_cnt),   FW'(vecs[k].exp_win));
      chk($sformatf("vec%0d_completes", k), FW'(compl_cnt), FW'(vecs[k].exp_compl));
      chk($sformatf("vec%0d_first", k),     FW'(first),     FW'(vecs[k].exp_first));
      chk($sformatf("vec%0d_cnt_end", k),   FW'(bus.cnt),   FW'(0));
    end

    // two frames back to back from reset: second start after 192+35 accepts
    do_reset();
    total_acc = 0; start_cnt = 0; start_at = 0;
    run_frame(vecs[0], first);
    run_frame(vecs[0], first);
    chk("b2b_start_count", FW'(start_cnt), FW'(2));
    chk("b2b_second_start", FW'(start_at), FW'(NPIX + 35));

    // frame aborted by sof on its 51st pixel
    win_cnt = 0; compl_cnt = 0;
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, DW'(i + 7));
    chk("abort_windows",   FW'(win_cnt),   FW'(14));
    chk("abort_completes", FW'(compl_cnt), FW'(0));
    run_frame('{stall_mode: 0, pat: 0, use_sof: 1'b1, exp_win: 140, exp_compl: 1, exp_first: 35}, first);
    chk("sof_first",     FW'(first),     FW'(35));
    chk("sof_windows",   FW'(win_cnt),   FW'(140));
    chk("sof_completes", FW'(compl_cnt), FW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
